// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register responder.
interface axi4_lite_reg_slave_if #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_BYTES = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_BYTES*8-1:0] awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_BYTES*8-1:0] wdata;
    logic [DATA_BYTES-1:0]   wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_BYTES*8-1:0] araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_BYTES*8-1:0] rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank with independent single-outstanding write and read paths.
// Define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_reg_slave #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_BYTES = 4,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    axi4_lite_reg_slave_if.slave             axil,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_out,
    output logic [NUM_REGS-1:0]              reg_wr
);
    localparam int unsigned W   = DATA_BYTES * 8;
    localparam int unsigned AW  = ADDR_BYTES * 8;
    localparam int unsigned LSB = $clog2(DATA_BYTES);

    localparam logic [1:0] RespOkay = 2'b00;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] RespOor  = 2'b10;
`else
    localparam logic [1:0] RespOor  = 2'b00;
`endif

    typedef logic [AW-1:0] addr_t;
    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RResp} r_state_e;

    function automatic addr_t word_index(input addr_t a);
        return a >> LSB;
    endfunction

    function automatic logic in_range(input addr_t a);
        return word_index(a) < addr_t'(NUM_REGS);
    endfunction

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic [W-1:0] regs_q [NUM_REGS];
    logic [W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
    logic aw_got_q, aw_got_d, w_got_q, w_got_d;
    addr_t awaddr_q, awaddr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [DATA_BYTES-1:0] wstrb_q, wstrb_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [W-1:0] rdata_q, rdata_d;

    addr_t wr_addr;
    logic [W-1:0] wr_data;
    logic [DATA_BYTES-1:0] wr_strb;
    logic aw_hs, w_hs, ar_hs;
    logic unused_prot;

    assign unused_prot = ^{axil.awprot, axil.arprot};
    assign aw_hs = axil.awvalid & awready_q;
    assign w_hs  = axil.wvalid & wready_q;
    assign ar_hs = axil.arvalid & arready_q;

    // Commit uses the held copy when a channel arrived earlier, else the live bus.
    assign wr_addr = aw_got_q ? awaddr_q : axil.awaddr;
    assign wr_data = w_got_q ? wdata_q : axil.wdata;
    assign wr_strb = w_got_q ? wstrb_q : axil.wstrb;

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        regs_d    = regs_q;
        case (w_state_q)
            WIdle: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = axil.awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = axil.wdata;
                    wstrb_d = axil.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    w_state_d = WResp;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = in_range(wr_addr) ? RespOkay : RespOor;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (word_index(wr_addr) == addr_t'(i)) begin
                            reg_wr_d[i] = 1'b1;
                            for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                                if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                            end
                        end
                    end
                end else begin
                    awready_d = ~aw_got_d;
                    wready_d  = ~w_got_d;
                end
            end
            WResp: begin
                if (axil.bready) begin
                    w_state_d = WIdle;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Reads sample regs_q, so a same-edge write commit is not visible yet.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = RResp;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = in_range(axil.araddr) ? RespOkay : RespOor;
                    rdata_d   = '0;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (word_index(axil.araddr) == addr_t'(i)) rdata_d = regs_q[i];
                    end
                end
            end
            RResp: begin
                if (axil.rready) begin
                    r_state_d = RIdle;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            reg_wr_q  <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            regs_q    <= regs_d;
            reg_wr_q  <= reg_wr_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axil.awready = awready_q;
    assign axil.wready  = wready_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;
    assign axil.arready = arready_q;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;
    assign reg_wr       = reg_wr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*W +: W] = regs_q[g];
    end
endmodule
